// File: rtl/cdb_if.sv
// Common data bus interface: three source push channels plus the registered CDB broadcast.
// "slave" is the arbiter side; "master" is the sources/consumer side.
interface cdb_if #(
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ROB_W-1:0]  alu_rob_id;
  logic [DATA_W-1:0] alu_val;

  logic              br_valid;
  logic              br_ready;
  logic [ROB_W-1:0]  br_rob_id;
  logic [DATA_W-1:0] br_val;

  logic              ld_valid;
  logic              ld_ready;
  logic [ROB_W-1:0]  ld_rob_id;
  logic [DATA_W-1:0] ld_val;

  logic              cdb_valid;
  logic [ROB_W-1:0]  cdb_rob_id;
  logic [DATA_W-1:0] cdb_val;
  logic [1:0]        cdb_src;

  modport master (
    output alu_valid, alu_rob_id, alu_val,
    output br_valid,  br_rob_id,  br_val,
    output ld_valid,  ld_rob_id,  ld_val,
    input  alu_ready, br_ready, ld_ready,
    input  cdb_valid, cdb_rob_id, cdb_val, cdb_src
  );

  modport slave (
    input  alu_valid, alu_rob_id, alu_val,
    input  br_valid,  br_rob_id,  br_val,
    input  ld_valid,  ld_rob_id,  ld_val,
    output alu_ready, br_ready, ld_ready,
    output cdb_valid, cdb_rob_id, cdb_val, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the ROB result port between ALU, branch and load FIFOs.
// Optional grant/stall statistics counters are enabled with `define CDB_STATS_EN.
module cdb_arbiter #(
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   rdy_in,
  input  logic   clear_in,
  cdb_if.slave   bus
`ifdef CDB_STATS_EN
  ,
  output logic [31:0] stat_alu_grants,
  output logic [31:0] stat_br_grants,
  output logic [31:0] stat_ld_grants,
  output logic [31:0] stat_stall_cycles
`endif
);
  localparam int NSRC  = 3;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ROB_W + DATA_W;

  logic              active;
  logic              flush;
  logic [NSRC-1:0]   src_valid;
  logic [NSRC-1:0]   src_ready;
  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   pop;
  logic [NSRC-1:0]   non_empty;
  logic [ENT_W-1:0]  src_data  [NSRC];
  logic [ENT_W-1:0]  head_data [NSRC];

  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic [1:0]        rr_ptr_reg;

  assign active = rdy_in && !clear_in;
  assign flush  = rdy_in && clear_in;

  assign src_valid   = {bus.ld_valid, bus.br_valid, bus.alu_valid};
  assign src_data[0] = {bus.alu_rob_id, bus.alu_val};
  assign src_data[1] = {bus.br_rob_id,  bus.br_val};
  assign src_data[2] = {bus.ld_rob_id,  bus.ld_val};
  assign bus.alu_ready = src_ready[0];
  assign bus.br_ready  = src_ready[1];
  assign bus.ld_ready  = src_ready[2];

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_fifo
      logic [ENT_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_reg;
      logic [CNT_W-1:0] count_reg;

      assign non_empty[gi] = (count_reg != '0);
      // Full FIFO refuses even when popping this cycle: no pass-through path.
      assign src_ready[gi] = !rst_in && active && (count_reg != CNT_W'(DEPTH));
      assign push[gi]      = src_valid[gi] && src_ready[gi];
      assign pop[gi]       = active && grant_valid && (grant_idx == 2'(gi));
      assign head_data[gi] = mem[rd_ptr_reg];

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else if (flush) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          count_reg <= count_reg + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
        end
      end

      always_ff @(posedge clk_in) begin
        if (push[gi]) mem[wr_ptr_reg] <= src_data[gi];
      end
    end
  endgenerate

  // Search order starts at rr_ptr and wraps ALU -> BR -> LD -> ALU.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    for (int k = 0; k < NSRC; k++) begin
      int c;
      c = (int'(rr_ptr_reg) + k) % NSRC;
      if (!grant_valid && non_empty[c]) begin
        grant_valid = 1'b1;
        grant_idx   = 2'(c);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus.cdb_valid  <= 1'b0;
      bus.cdb_rob_id <= '0;
      bus.cdb_val    <= '0;
      bus.cdb_src    <= 2'd0;
      rr_ptr_reg     <= 2'd0;
    end else if (flush) begin
      bus.cdb_valid <= 1'b0;
      rr_ptr_reg    <= 2'd0;
    end else if (active) begin
      if (grant_valid) begin
        bus.cdb_valid                   <= 1'b1;
        {bus.cdb_rob_id, bus.cdb_val}   <= head_data[grant_idx];
        bus.cdb_src                     <= grant_idx;
        rr_ptr_reg                      <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      end else begin
        bus.cdb_valid <= 1'b0;
      end
    end
  end

`ifdef CDB_STATS_EN
  logic [31:0] grant_cnt_reg [NSRC];
  logic [31:0] stall_cnt_reg;

  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_stat
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)       grant_cnt_reg[gi] <= '0;
        else if (pop[gi]) grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 32'd1;
      end
    end
  endgenerate

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      stall_cnt_reg <= '0;
    else if (rdy_in && |(src_valid & ~src_ready))
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign stat_alu_grants   = grant_cnt_reg[0];
  assign stat_br_grants    = grant_cnt_reg[1];
  assign stat_ld_grants    = grant_cnt_reg[2];
  assign stat_stall_cycles = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus queues expected broadcasts, a negedge monitor checks them.
module tb_cdb_arbiter;
  logic clk_in   = 1'b0;
  logic rst_in   = 1'b0;
  logic rdy_in   = 1'b1;
  logic clear_in = 1'b0;

  cdb_if bus();

`ifdef CDB_STATS_EN
  logic [31:0] s_alu, s_br, s_ld, s_stall;
`endif

  cdb_arbiter dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear_in (clear_in),
    .bus      (bus)
`ifdef CDB_STATS_EN
    ,
    .stat_alu_grants   (s_alu),
    .stat_br_grants    (s_br),
    .stat_ld_grants    (s_ld),
    .stat_stall_cycles (s_stall)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] val;
    logic [1:0]  src;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_bcast(input logic [4:0] id, input logic [31:0] val, input logic [1:0] src);
    exp_t e;
    e.id = id; e.val = val; e.src = src;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.br_valid  = 1'b0;
    bus.ld_valid  = 1'b0;
  endtask

  task automatic reset_dut();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic check_readies(input string name, input logic [2:0] req);
    check(name, {61'd0, bus.ld_ready, bus.br_ready, bus.alu_ready}, {61'd0, req});
  endtask

  // Monitor: every broadcast must match the head of the expectation queue.
  always @(negedge clk_in) begin
    if (bus.cdb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_bcast: actual id=%0d val=%0h src=%0d required none",
                 bus.cdb_rob_id, bus.cdb_val, bus.cdb_src);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] bcast id=%0d val=%0h src=%0d", bus.cdb_rob_id, bus.cdb_val, bus.cdb_src);
        check("cdb_rob_id", 64'(bus.cdb_rob_id), 64'(e.id));
        check("cdb_val",    64'(bus.cdb_val),    64'(e.val));
        check("cdb_src",    64'(bus.cdb_src),    64'(e.src));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int stalls;
    int guard;
    logic rdy_s;

    idle();
    bus.alu_rob_id = '0; bus.alu_val = '0;
    bus.br_rob_id  = '0; bus.br_val  = '0;
    bus.ld_rob_id  = '0; bus.ld_val  = '0;

    // Reset state
    #1 rst_in = 1'b1;
    #2;
    check("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_cdb_rob_id", 64'(bus.cdb_rob_id), 64'd0);
    check("rst_cdb_val", 64'(bus.cdb_val), 64'd0);
    check("rst_cdb_src", 64'(bus.cdb_src), 64'd0);
    check_readies("rst_readies", 3'b000);
    tick();
    tick();
    rst_in = 1'b0;
    #1;
    check_readies("post_rst_readies", 3'b111);

    // 1: single ALU push, broadcast only in the cycle after the following edge
    bus.alu_valid = 1'b1; bus.alu_rob_id = 5'd5; bus.alu_val = 32'h1234;
    expect_bcast(5'd5, 32'h1234, 2'd0);
    tick();
    idle();
    @(negedge clk_in); check("t1_valid_e1", 64'(bus.cdb_valid), 64'd0);
    @(negedge clk_in); check("t1_valid_e2", 64'(bus.cdb_valid), 64'd1);
    @(negedge clk_in); check("t1_valid_e3", 64'(bus.cdb_valid), 64'd0);

    // 2: three simultaneous pushes from reset, three consecutive broadcasts
    reset_dut();
    bus.alu_valid = 1'b1; bus.alu_rob_id = 5'd1; bus.alu_val = 32'h11;
    bus.br_valid  = 1'b1; bus.br_rob_id  = 5'd2; bus.br_val  = 32'h22;
    bus.ld_valid  = 1'b1; bus.ld_rob_id  = 5'd3; bus.ld_val  = 32'h33;
    expect_bcast(5'd1, 32'h11, 2'd0);
    expect_bcast(5'd2, 32'h22, 2'd1);
    expect_bcast(5'd3, 32'h33, 2'd2);
    tick();
    idle();
    @(negedge clk_in); check("t2_valid_e1", 64'(bus.cdb_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in); check("t2_valid_run", 64'(bus.cdb_valid), 64'd1);
    end
    @(negedge clk_in); check("t2_valid_after", 64'(bus.cdb_valid), 64'd0);

    // 3: ALU pushes every cycle while BR and LD hold one entry each
    @(posedge clk_in); #1;
    bus.alu_valid = 1'b1; bus.alu_rob_id = 5'd8;  bus.alu_val = 32'h80;
    bus.br_valid  = 1'b1; bus.br_rob_id  = 5'd9;  bus.br_val  = 32'h90;
    bus.ld_valid  = 1'b1; bus.ld_rob_id  = 5'd10; bus.ld_val  = 32'ha0;
    expect_bcast(5'd8,  32'h80, 2'd0);
    expect_bcast(5'd9,  32'h90, 2'd1);
    expect_bcast(5'd10, 32'ha0, 2'd2);
    expect_bcast(5'd11, 32'hb0, 2'd0);
    expect_bcast(5'd12, 32'hc0, 2'd0);
    expect_bcast(5'd13, 32'hd0, 2'd0);
    tick();
    bus.br_valid = 1'b0;
    bus.ld_valid = 1'b0;
    idx = 1; stalls = 0; guard = 0;
    while (idx <= 3 && guard < 20) begin
      bus.alu_valid  = 1'b1;
      bus.alu_rob_id = 5'(10 + idx);
      bus.alu_val    = 32'(32'h00a0 + 32'h10 * idx);
      #1;
      rdy_s = bus.alu_ready;
      if (!rdy_s) stalls++;
      tick();
      if (rdy_s) idx++;
      guard++;
    end
    idle();
    check("t3_alu_stall_cycles", 64'(stalls), 64'd2);
    repeat (4) tick();

    // 4: flush with LD holding two entries and a simultaneous ALU push
    reset_dut();
    bus.alu_valid = 1'b1; bus.alu_rob_id = 5'd14; bus.alu_val = 32'he0;
    bus.br_valid  = 1'b1; bus.br_rob_id  = 5'd15; bus.br_val  = 32'hf0;
    bus.ld_valid  = 1'b1; bus.ld_rob_id  = 5'd16; bus.ld_val  = 32'h100;
    expect_bcast(5'd14, 32'he0, 2'd0);
    tick();
    bus.alu_valid = 1'b0; bus.br_valid = 1'b0;
    bus.ld_rob_id = 5'd17; bus.ld_val = 32'h110;
    tick();
    bus.ld_valid = 1'b0;
    clear_in = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rob_id = 5'd18; bus.alu_val = 32'h120;
    tick();
    clear_in = 1'b0;
    idle();
    @(negedge clk_in);
    check("t4_valid_after_flush", 64'(bus.cdb_valid), 64'd0);
    check_readies("t4_readies_after_flush", 3'b111);
    repeat (3) tick();
    // rr pointer returned to ALU by the flush
    bus.alu_valid = 1'b1; bus.alu_rob_id = 5'd20; bus.alu_val = 32'h1400;
    bus.br_valid  = 1'b1; bus.br_rob_id  = 5'd19; bus.br_val  = 32'h1900;
    expect_bcast(5'd20, 32'h1400, 2'd0);
    expect_bcast(5'd19, 32'h1900, 2'd1);
    tick();
    idle();
    repeat (4) tick();

    // 5: freeze with one entry pending
    bus.alu_valid = 1'b1; bus.alu_rob_id = 5'd21; bus.alu_val = 32'h2100;
    expect_bcast(5'd21, 32'h2100, 2'd0);
    tick();
    rdy_in = 1'b0;
    idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      check("t5_frz_valid", 64'(bus.cdb_valid), 64'd0);
      check("t5_frz_rob_id", 64'(bus.cdb_rob_id), 64'd19);
      check("t5_frz_val", 64'(bus.cdb_val), 64'h1900);
      check("t5_frz_src", 64'(bus.cdb_src), 64'd1);
      check_readies("t5_frz_readies", 3'b000);
      if (k < 3) tick();
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("t5_bcast_valid", 64'(bus.cdb_valid), 64'd1);
    check("t5_bcast_rob_id", 64'(bus.cdb_rob_id), 64'd21);
    repeat (3) tick();

    // 6: asynchronous reset while a broadcast is live
    bus.alu_valid = 1'b1; bus.alu_rob_id = 5'd22; bus.alu_val = 32'h2200;
    bus.br_valid  = 1'b1; bus.br_rob_id  = 5'd23; bus.br_val  = 32'h2300;
    tick();
    idle();
    @(posedge clk_in);
    #2;
    check("t6_valid_before_rst", 64'(bus.cdb_valid), 64'd1);
    rst_in = 1'b1;
    #1;
    check("t6_valid_async_rst", 64'(bus.cdb_valid), 64'd0);
    check("t6_rob_id_async_rst", 64'(bus.cdb_rob_id), 64'd0);
    check_readies("t6_readies_in_rst", 3'b000);
    tick();
    rst_in = 1'b0;
    #1;
    check_readies("t6_readies_after_rst", 3'b111);
    repeat (5) tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the reorder buffer's single result-write port (the common data bus) between three execution sources: ALU, branch unit and load unit.
- Each source pushes (rob_id, value) pairs into its own small FIFO.
- A round-robin arbiter pops at most one entry per cycle into a registered CDB output.
- The CDB output drives the ROB set port and the RS/LSB wakeup logic.
- The block also applies back-pressure to the sources and honours the ROB misprediction flush.

Parameters:
ROB_W, 5, width of ROB index carried with each result
DATA_W, 32, width of result value
DEPTH, 2, entries per source FIFO (power of two, >=2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-high
rdy_in  input  1  global ready; low = freeze all state
clear_in  input  1  ROB flush (branch mispredict); acts only when rdy_in=1
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU FIFO can accept
alu_rob_id  input  ROB_W  ALU result ROB index
alu_val  input  DATA_W  ALU result value
br_valid / br_ready / br_rob_id / br_val  as ALU, for branch unit
ld_valid / ld_ready / ld_rob_id / ld_val  as ALU, for load unit
cdb_valid  output  1  broadcast valid this cycle
cdb_rob_id  output  ROB_W  broadcast ROB index
cdb_val  output  DATA_W  broadcast value
cdb_src  output  2  granted source (0 ALU, 1 BR, 2 LD), debug

Behaviour:
- Reset (async, rst_in=1):
  - FIFOs empty; counts 0; rr_ptr=0.
  - cdb_valid=0, cdb_rob_id=0, cdb_val=0, cdb_src=0.
  - All *_ready=0 while rst_in is high.
- Ready (combinational): x_ready = rdy_in && !clear_in && count_x != DEPTH. A full FIFO deasserts ready even if it pops in the same cycle; there is no pass-through.
- Push: at the clock edge, if rdy_in && !clear_in && x_valid && x_ready, the entry is written at wr_ptr_x. The pointer wraps modulo DEPTH. A valid offered without ready is ignored; the source must hold it.
- Arbitration (combinational, from registered FIFO state):
  - Candidate set = non-empty FIFOs.
  - Search starts at rr_ptr in order ALU -> BR -> LD -> ALU.
  - The first candidate found is granted.
- Pop and output, at an edge with rdy_in && !clear_in:
  - If a grant exists: the head entry is moved into the cdb_* registers, cdb_valid<=1, cdb_src<=granted, and rr_ptr<=(granted+1) mod 3.
  - If no grant: cdb_valid<=0, cdb_rob_id and cdb_val hold their old values, rr_ptr holds.
- Latency: a result pushed at edge E is broadcast in the cycle after edge E+1 at the earliest. cdb_valid is high for exactly one cycle per entry.
- Throughput: one broadcast per cycle. Each source is guaranteed a grant within 3 cycles while its FIFO is non-empty.
- Same-cycle push and pop on one FIFO: both occur; count unchanged.
- Flush (rdy_in && clear_in at an edge):
  - All FIFOs emptied, cdb_valid<=0, rr_ptr<=0.
  - Pushes and pops in that cycle are discarded.
  - Flush has priority over everything except reset.
- Freeze (rdy_in=0): all registers hold, cdb_* outputs stay stable, *_ready=0, and no push or pop occurs.
- Reset mid-operation: immediate async clear regardless of clock or rdy_in. Pending entries are lost.
- Counts are ceil(log2(DEPTH+1)) bits wide; read and write pointers are log2(DEPTH) bits and wrap naturally.

Optional Feature:
CDB_STATS_EN
- Defined:
  - Adds 32-bit output ports stat_alu_grants, stat_br_grants, stat_ld_grants and stat_stall_cycles.
  - A grant counter increments on each pop from its source.
  - stat_stall_cycles increments on each rdy_in=1 edge where any x_valid=1 && x_ready=0.
  - Counters reset to 0 on rst_in only (not on clear_in), hold while rdy_in=0, and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset then single push alu_valid=1, alu_rob_id=5, alu_val=0x1234 at edge 1 -> cdb_valid=1, cdb_rob_id=5, cdb_val=0x1234, cdb_src=0 in the cycle after edge 2 only.
2. All three sources push simultaneously (ids 1, 2, 3) from reset -> broadcasts in order id1 (ALU), id2 (BR), id3 (LD) on three consecutive cycles; rr_ptr ends at 0.
3. ALU pushes every cycle (DEPTH=2) while BR and LD each hold one entry -> grant order ALU, BR, LD, ALU, ...; alu_ready drops when count reaches 2; no entry is lost or duplicated.
4. Fill LD FIFO with 2 entries, then assert clear_in with rdy_in=1 and a simultaneous alu push -> next cycle cdb_valid=0, all *_ready=1, no broadcast of flushed entries or of the ALU push.
5. With one entry pending, hold rdy_in=0 for 4 cycles -> cdb_* outputs unchanged and *_ready=0; on rdy_in=1 the entry broadcasts on the next edge.
6. Assert rst_in asynchronously between clock edges while cdb_valid=1 -> cdb_valid falls to 0 immediately without a clock edge; FIFOs empty after release.
